tod_alarm_timer: RTL and testbench
==================================

Name: tod_alarm_timer

Overview:
- Parametrised time-of-day timer for the seating-system scheduler.
- Core function:
  - Divides `clk` into minute ticks.
  - Keeps hour and minute registers with correct wrap-around.
  - Accepts a synchronous time load.
  - Compares the current time against N programmable alarm channels (class-period boundaries).
- Each armed channel raises a one-cycle pulse plus a sticky pending flag. Both feed the seat-assignment controller.

Parameters:
- TICKS_PER_MIN, 2: number of `tick_en`-qualified clk cycles per minute; must be ≥1.
- HOURS_PER_DAY, 24: hour wraps from HOURS_PER_DAY-1 to 0; must be ≤32.
- N_ALARM, 4: number of alarm channels; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- tick_en  in  1  advances the prescaler when 1; holds it when 0.
- load_valid  in  1  load time this cycle.
- load_hour  in  5  hour to load.
- load_min  in  6  minute to load.
- alarm_we  in  1  write alarm channel `alarm_idx`.
- alarm_idx  in  $clog2(N_ALARM) (min 1)  channel to write.
- alarm_hour  in  5  alarm hour.
- alarm_min  in  6  alarm minute.
- alarm_arm  in  1  armed bit written with the channel.
- alarm_ack  in  N_ALARM  clears the pending bit of each channel.
- minute_tick  out  1  one-cycle pulse when the minute advances.
- time_out  out  11  {hour[4:0], min[5:0]}.
- alarm_pulse  out  N_ALARM  one-cycle fire pulse per channel.
- alarm_pending  out  N_ALARM  sticky fired flag per channel.

Behaviour:
- Reset, when rst_n=0 at posedge:
  - Prescaler, hour and min go to 0.
  - Outputs: time_out=0, minute_tick=0, alarm_pulse=0, alarm_pending=0.
  - Every alarm channel: value 0, disarmed.
  - Reset overrides every other input in the same cycle.
- Prescaler:
  - Counts 0..TICKS_PER_MIN-1 on cycles with tick_en=1.
  - At terminal count with tick_en=1, it returns to 0 and an advance occurs.
  - TICKS_PER_MIN=1: every tick_en cycle is an advance.
- Advance:
  - min increments. If min=59, min becomes 0 and hour increments.
  - hour=HOURS_PER_DAY-1 together with min=59 wraps to 00:00.
  - minute_tick=1 in the cycle after the advance clock edge, i.e. coincident with the new time_out.
- Load, when load_valid=1:
  - Takes priority over an advance in the same cycle.
  - Loads hour/min, clears the prescaler, and suppresses minute_tick.
  - time_out shows the new value the next cycle.
  - Out-of-range load (min>59 or hour≥HOURS_PER_DAY) is ignored entirely, including the prescaler.
- Alarm write:
  - When alarm_we=1, channel alarm_idx value and arm bit update at the edge.
  - alarm_idx≥N_ALARM is ignored.
  - Out-of-range alarm values are stored but can never match.
  - A write never causes a fire by itself, even if the value equals the current time.
- Fire condition for channel k:
  - The time registers change, by advance or by a valid load, to a value equal to channel k.
  - Channel k is armed.
  - The comparison uses the channel value as it stood before any same-cycle write.
  - A load to the same value as the current time counts as a change and fires.
  - The cycle the new time_out appears, alarm_pulse[k]=1 for exactly one cycle and alarm_pending[k] becomes 1.
- Pending and ack:
  - alarm_pending[k] stays set until alarm_ack[k]=1, which clears it next cycle.
  - Ack in the same cycle as a new fire: pending remains 1.
- Fire rate:
  - A match fires once per entry into the matching time.
  - Holding at the matching time (tick_en=0) does not re-fire.
- Latency: all outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro: TOD_ALARM_TIMER_AUTODISARM_EN.
- Defined:
  - A channel that fires is automatically disarmed in the same edge that sets pending (one-shot alarm).
  - A same-cycle alarm_we to that channel wins, and its arm bit is written.
- Undefined: channels stay armed after firing (repeating daily alarm).
- Port list is identical in both builds.

Decomposition:
- Package tod_pkg:
  - typedef hour_t (logic [4:0]), min_t (logic [5:0]).
  - typedef tod_t as a packed struct {hour_t hour; min_t min;}.
  - Constant MIN_PER_HOUR=60.
  - Function tod_valid(tod_t, hours_per_day).
- Sub-module tod_alarm_chan: one alarm channel (value/arm registers, compare, pulse, pending, autodisarm), instantiated N_ALARM times by generate.

Test Plan:
- Reset and count, TICKS_PER_MIN=2, tick_en=1: after reset, time_out=00:00. After 4 cycles, time_out=00:02, with minute_tick pulsing once per 2 cycles.
- Wrap: load 23:59, then one advance → time_out=00:00 and minute_tick=1. Load 05:59, then one advance → 06:00.
- Load priority and validation:
  - load_valid coinciding with a terminal prescaler count → loaded value, no minute_tick, next advance 2 tick cycles later.
  - Load 12:60 or 24:00 → time unchanged.
- Alarm fire: arm ch2 at 08:30, load 08:29, advance → alarm_pulse=4'b0100 for one cycle and pending[2]=1 held. Hold tick_en=0 for 10 cycles → no re-pulse.
- Ack race: ch2 pending, then assert alarm_ack[2] in the same cycle as a new ch2 fire → pending[2] stays 1. Ack alone → 0 next cycle.
- Write-no-fire and autodisarm:
  - Write ch0=current time, armed → no pulse.
  - With TOD_ALARM_TIMER_AUTODISARM_EN: ch0 fires once, then after a 24 h wrap it does not fire. Without the macro it fires again.

Source files
------------

// File: rtl/tod_pkg.sv
// Shared time-of-day types and helpers for tod_alarm_timer.
// Optional build macro used by the block: TOD_ALARM_TIMER_AUTODISARM_EN.
package tod_pkg;

    typedef logic [4:0] hour_t;
    typedef logic [5:0] min_t;

    typedef struct packed {
        hour_t hour;
        min_t  min;
    } tod_t;

    localparam int MIN_PER_HOUR = 60;

    // True when the time is a legal clock reading for a day of hours_per_day hours.
    function automatic logic tod_valid(input tod_t t, input int hours_per_day);
        logic ok_s;
        ok_s = (int'(t.min) < MIN_PER_HOUR) && (int'(t.hour) < hours_per_day);
        return ok_s;
    endfunction

endpackage

// File: rtl/tod_alarm_chan.sv
// One alarm channel: stored value/arm bit, compare against the incoming time, pulse and sticky pending.
// With TOD_ALARM_TIMER_AUTODISARM_EN defined, a firing channel disarms itself (one-shot).
module tod_alarm_chan
    import tod_pkg::*;
#(
    parameter int HOURS_PER_DAY = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic we,
    input  tod_t wr_value,
    input  logic wr_arm,
    input  logic ack,
    input  logic time_change,
    input  tod_t time_next,
    output logic pulse,
    output logic pending
);

    tod_t value_r;
    logic arm_r;
    logic pulse_r;
    logic pending_r;
    logic fire_s;

    // Fire only when the time registers are about to take on this channel's (pre-write) value.
    always_comb begin
        fire_s = arm_r && time_change && (time_next == value_r)
                 && tod_valid(value_r, HOURS_PER_DAY);
    end

    // Channel state; a fire in the same cycle as an ack leaves pending set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_r   <= tod_t'(11'd0);
            arm_r     <= 1'b0;
            pulse_r   <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            pulse_r   <= fire_s;
            pending_r <= fire_s | (pending_r & ~ack);
            if (we) begin
                value_r <= wr_value;
                arm_r   <= wr_arm;
            end
`ifdef TOD_ALARM_TIMER_AUTODISARM_EN
            else if (fire_s) begin
                arm_r <= 1'b0;
            end
`endif
        end
    end

    assign pulse   = pulse_r;
    assign pending = pending_r;

endmodule

// File: rtl/tod_alarm_timer.sv
// Time-of-day timer with minute prescaler, validated time load and N_ALARM alarm channels.
// Build option: TOD_ALARM_TIMER_AUTODISARM_EN makes every channel one-shot.
module tod_alarm_timer
    import tod_pkg::*;
#(
    parameter int TICKS_PER_MIN = 2,
    parameter int HOURS_PER_DAY = 24,
    parameter int N_ALARM       = 4,
    localparam int AW           = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_en,
    input  logic               load_valid,
    input  logic [4:0]         load_hour,
    input  logic [5:0]         load_min,
    input  logic               alarm_we,
    input  logic [AW-1:0]      alarm_idx,
    input  logic [4:0]         alarm_hour,
    input  logic [5:0]         alarm_min,
    input  logic               alarm_arm,
    input  logic [N_ALARM-1:0] alarm_ack,
    output logic               minute_tick,
    output logic [10:0]        time_out,
    output logic [N_ALARM-1:0] alarm_pulse,
    output logic [N_ALARM-1:0] alarm_pending
);

    localparam int PW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;

    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_next_s;
    tod_t          time_r;
    tod_t          time_next_s;
    tod_t          load_tod_s;
    tod_t          adv_tod_s;
    tod_t          alarm_tod_s;
    logic          load_ok_s;
    logic          terminal_s;
    logic          change_s;
    logic          minute_tick_r;

    // Qualify the load request and detect the prescaler's terminal count.
    always_comb begin
        load_tod_s  = '{hour: load_hour, min: load_min};
        alarm_tod_s = '{hour: alarm_hour, min: alarm_min};
        load_ok_s   = load_valid && tod_valid(load_tod_s, HOURS_PER_DAY);
        terminal_s  = tick_en && (presc_r == PW'(TICKS_PER_MIN - 1));
    end

    // Time one minute later, with hour and day wrap.
    always_comb begin
        adv_tod_s = time_r;
        if (time_r.min == min_t'(MIN_PER_HOUR - 1)) begin
            adv_tod_s.min = 6'd0;
            if (time_r.hour == hour_t'(HOURS_PER_DAY - 1)) begin
                adv_tod_s.hour = 5'd0;
            end else begin
                adv_tod_s.hour = time_r.hour + 5'd1;
            end
        end else begin
            adv_tod_s.min = time_r.min + 6'd1;
        end
    end

    // Next time/prescaler: a valid load beats an advance and restarts the minute.
    always_comb begin
        time_next_s  = time_r;
        presc_next_s = presc_r;
        change_s     = 1'b0;
        if (load_ok_s) begin
            time_next_s  = load_tod_s;
            presc_next_s = PW'(0);
            change_s     = 1'b1;
        end else if (terminal_s) begin
            time_next_s  = adv_tod_s;
            presc_next_s = PW'(0);
            change_s     = 1'b1;
        end else if (tick_en) begin
            presc_next_s = presc_r + PW'(1);
        end else begin
            presc_next_s = presc_r;
        end
    end

    // Time, prescaler and minute tick registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            time_r        <= tod_t'(11'd0);
            presc_r       <= PW'(0);
            minute_tick_r <= 1'b0;
        end else begin
            time_r        <= time_next_s;
            presc_r       <= presc_next_s;
            minute_tick_r <= terminal_s & ~load_ok_s;
        end
    end

    for (genvar k = 0; k < N_ALARM; k++) begin : g_chan
        tod_alarm_chan #(
            .HOURS_PER_DAY(HOURS_PER_DAY)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .we         (alarm_we && (alarm_idx == AW'(k))),
            .wr_value   (alarm_tod_s),
            .wr_arm     (alarm_arm),
            .ack        (alarm_ack[k]),
            .time_change(change_s),
            .time_next  (time_next_s),
            .pulse      (alarm_pulse[k]),
            .pending    (alarm_pending[k])
        );
    end

    assign time_out    = time_r;
    assign minute_tick = minute_tick_r;

endmodule

// File: tb/tb_tod_alarm_timer.sv
// Scoreboard bench for tod_alarm_timer: a minute-of-day reference model predicts each cycle's outputs.
// Honours TOD_ALARM_TIMER_AUTODISARM_EN when the design is built with it.
module tb_tod_alarm_timer;

    localparam int TPM = 2;
    localparam int HPD = 24;
    localparam int NA  = 4;
    localparam int DAY = HPD * 60;

    logic        clk;
    logic        rst_n;
    logic        tick_en;
    logic        load_valid;
    logic [4:0]  load_hour;
    logic [5:0]  load_min;
    logic        alarm_we;
    logic [1:0]  alarm_idx;
    logic [4:0]  alarm_hour;
    logic [5:0]  alarm_min;
    logic        alarm_arm;
    logic [3:0]  alarm_ack;
    logic        minute_tick;
    logic [10:0] time_out;
    logic [3:0]  alarm_pulse;
    logic [3:0]  alarm_pending;

    tod_alarm_timer #(
        .TICKS_PER_MIN(TPM),
        .HOURS_PER_DAY(HPD),
        .N_ALARM(NA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick_en(tick_en),
        .load_valid(load_valid), .load_hour(load_hour), .load_min(load_min),
        .alarm_we(alarm_we), .alarm_idx(alarm_idx), .alarm_hour(alarm_hour),
        .alarm_min(alarm_min), .alarm_arm(alarm_arm), .alarm_ack(alarm_ack),
        .minute_tick(minute_tick), .time_out(time_out),
        .alarm_pulse(alarm_pulse), .alarm_pending(alarm_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] t;
        logic        tick;
        logic [3:0]  pulse;
        logic [3:0]  pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state: time as minutes since midnight.
    int tod_m;
    int presc_m;
    int ahr_m[NA];
    int amn_m[NA];
    bit arm_m[NA];
    bit pend_m[NA];

`ifdef TOD_ALARM_TIMER_AUTODISARM_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: one expected record per clock edge, compared away from the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("time_out", time_out, e.t);
            chk("minute_tick", {10'd0, minute_tick}, {10'd0, e.tick});
            chk("alarm_pulse", {7'd0, alarm_pulse}, {7'd0, e.pulse});
            chk("alarm_pending", {7'd0, alarm_pending}, {7'd0, e.pend});
        end
    end

    // Apply current inputs to the model, queue the prediction, then clock once.
    task automatic cycle();
        exp_t e;
        bit   chg;
        bit   tick;
        int   new_tod;
        bit [3:0] pul;
        chg = 1'b0; tick = 1'b0; pul = 4'd0;
        if (!rst_n) begin
            tod_m = 0; presc_m = 0;
            for (int k = 0; k < NA; k++) begin
                ahr_m[k] = 0; amn_m[k] = 0; arm_m[k] = 1'b0; pend_m[k] = 1'b0;
            end
        end else begin
            new_tod = tod_m;
            if (load_valid && int'(load_min) < 60 && int'(load_hour) < HPD) begin
                new_tod = int'(load_hour) * 60 + int'(load_min);
                presc_m = 0;
                chg = 1'b1;
            end else if (tick_en) begin
                if (presc_m == TPM - 1) begin
                    presc_m = 0;
                    new_tod = (tod_m + 1) % DAY;
                    chg = 1'b1;
                    tick = 1'b1;
                end else begin
                    presc_m++;
                end
            end
            for (int k = 0; k < NA; k++) begin
                pul[k] = chg && arm_m[k] && amn_m[k] < 60 && ahr_m[k] < HPD
                         && (ahr_m[k] * 60 + amn_m[k] == new_tod);
                pend_m[k] = pul[k] || (pend_m[k] && !alarm_ack[k]);
                if (alarm_we && int'(alarm_idx) == k) begin
                    ahr_m[k] = int'(alarm_hour);
                    amn_m[k] = int'(alarm_min);
                    arm_m[k] = alarm_arm;
                end else if (AUTO && pul[k]) begin
                    arm_m[k] = 1'b0;
                end
            end
            tod_m = new_tod;
        end
        e.t     = {5'(tod_m / 60), 6'(tod_m % 60)};
        e.tick  = tick;
        e.pulse = pul;
        for (int k = 0; k < NA; k++) e.pend[k] = pend_m[k];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1; tick_en = 1'b0; load_valid = 1'b0; load_hour = 5'd0; load_min = 6'd0;
        alarm_we = 1'b0; alarm_idx = 2'd0; alarm_hour = 5'd0; alarm_min = 6'd0;
        alarm_arm = 1'b0; alarm_ack = 4'd0;
    endtask

    task automatic run(input int n, input bit te);
        for (int i = 0; i < n; i++) begin
            idle();
            tick_en = te;
            cycle();
        end
    endtask

    task automatic load(input int h, input int m, input bit te);
        idle();
        tick_en = te; load_valid = 1'b1; load_hour = 5'(h); load_min = 6'(m);
        cycle();
    endtask

    task automatic wr_alarm(input int idx, input int h, input int m, input bit arm);
        idle();
        alarm_we = 1'b1; alarm_idx = 2'(idx); alarm_hour = 5'(h); alarm_min = 6'(m);
        alarm_arm = arm;
        cycle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        cycle();
        cycle();
        // Count from reset
        run(4, 1'b1);
        // Hour and day wrap
        load(23, 59, 1'b0);
        run(2, 1'b1);
        load(5, 59, 1'b0);
        run(2, 1'b1);
        // Load colliding with the terminal prescaler count
        run(1, 1'b1);
        load(14, 10, 1'b1);
        run(3, 1'b1);
        // Out-of-range loads
        run(1, 1'b1);
        load(12, 60, 1'b1);
        load(24, 0, 1'b1);
        run(2, 1'b1);
        // Alarm fire and hold
        wr_alarm(2, 8, 30, 1'b1);
        load(8, 29, 1'b0);
        run(2, 1'b1);
        run(10, 1'b0);
        // Ack racing a new fire, then ack alone
        load(8, 30, 1'b0);
        idle(); alarm_ack = 4'b0100; load_valid = 1'b1; load_hour = 5'd8; load_min = 6'd30;
        cycle();
        idle(); alarm_ack = 4'b0100;
        cycle();
        run(2, 1'b0);
        // Write equal to current time, then two full days
        wr_alarm(0, 8, 30, 1'b1);
        run(3, 1'b0);
        run(2 * DAY, 1'b1);
        run(2 * DAY, 1'b1);
        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int off;
            idle();
            rst_n   = ($urandom_range(0, 399) != 0);
            tick_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                load_valid = 1'b1;
                load_hour  = 5'($urandom_range(0, 25));
                load_min   = 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 7) == 0) begin
                off        = (tod_m + int'($urandom_range(0, 3))) % DAY;
                alarm_we   = 1'b1;
                alarm_idx  = 2'($urandom_range(0, 3));
                alarm_hour = 5'(off / 60);
                alarm_min  = ($urandom_range(0, 9) == 0) ? 6'd61 : 6'(off % 60);
                alarm_arm  = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 9) == 0) alarm_ack = 4'($urandom_range(0, 15));
            cycle();
        end
        idle();
        @(negedge clk);
        #1;
        chk("queue_drained", 11'(exp_q.size()), 11'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
